// File: rtl/uart_frame_packer_pkg.sv
// Shared types and defaults for the UART-to-DDR3 frame packer.
// Holds the FSM encoding, the frame defaults and the byte shift helper.
package uart_frame_packer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] SYNC_WORD_DEF   = 32'hA5A5_5A5A;
  localparam int          FRAME_WORDS_DEF = 307200;
  localparam int          TIMEOUT_CYC_DEF = 5430;
  localparam int          WCNT_W          = 20;

  function automatic logic [31:0] shift_in(
    input logic [31:0] r,
    input logic [7:0]  b
  );
    return {r[23:0], b};
  endfunction

endpackage

// File: rtl/uart_frame_packer.sv
// Finds the sync word in the UART byte stream and packs the
// payload MSB-first into FIFO words, one frame at a time.
//   clk, rst_n            clock and async active-low reset
//   rx_data, rx_valid     received byte and its 1-cycle strobe
//   fifo_wr_data/_en      packed word and its 1-cycle write strobe
//   frame_active          high while receiving payload
//   frame_done            pulse after the last word of a frame
//   err_timeout           pulse when an idle gap aborts the frame
//   word_cnt              words written in the current frame
module uart_frame_packer
  import uart_frame_packer_pkg::*;
#(
  parameter int          FIFO_WR_WIDTH = 32,
  parameter int          FIFO_WR_BYTE  = 4,
  parameter int          FRAME_WORDS   = FRAME_WORDS_DEF,
  parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int          TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
  output logic                     fifo_wr_en,
  output logic                     frame_active,
  output logic                     frame_done,
  output logic                     err_timeout,
  output logic [WCNT_W-1:0]        word_cnt
);

  localparam int BW =
    (FIFO_WR_BYTE > 1) ? $clog2(FIFO_WR_BYTE) : 1;
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int W  = FIFO_WR_WIDTH;

  localparam logic [BW-1:0] LAST_BYTE =
    BW'(FIFO_WR_BYTE - 1);
  localparam logic [IW-1:0] IDLE_LAST =
    IW'(TIMEOUT_CYC - 1);
  localparam logic [WCNT_W-1:0] FRAME_LAST =
    WCNT_W'(FRAME_WORDS - 1);

  state_e            state_q, state_d;
  logic [31:0]       hunt_q, hunt_d;
  logic [W-1:0]      pack_q, pack_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;

  logic [31:0]  hunt_nx;
  logic [W-1:0] pack_nx;

  assign hunt_nx = shift_in(hunt_q, rx_data);
  assign pack_nx = {pack_q[W-9:0], rx_data};

  always_comb begin
    state_d = state_q;
    hunt_d  = hunt_q;
    pack_d  = pack_q;
    byte_d  = byte_q;
    idle_d  = idle_q;
    wcnt_d  = wcnt_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (rx_valid) begin
          hunt_d = hunt_nx;
          if (hunt_nx == SYNC_WORD) begin
            state_d = ST_RECV;
            hunt_d  = '0;
            byte_d  = '0;
            idle_d  = '0;
            wcnt_d  = '0;
          end
        end
      end
      ST_RECV: begin
        // A byte on the last idle cycle wins over the abort.
        if (rx_valid) begin
          idle_d = '0;
          pack_d = pack_nx;
          if (byte_q == LAST_BYTE) begin
            byte_d  = '0;
            wen_d   = 1'b1;
            wdata_d = pack_nx;
            wcnt_d  = wcnt_q + WCNT_W'(1);
            if (wcnt_q == FRAME_LAST) begin
              state_d = ST_DONE;
            end
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end else if (idle_q == IDLE_LAST) begin
          // Partial word is dropped; word_cnt stays frozen.
          tmo_d   = 1'b1;
          state_d = ST_HUNT;
          hunt_d  = '0;
          byte_d  = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_HUNT;
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      hunt_q  <= '0;
      pack_q  <= '0;
      byte_q  <= '0;
      idle_q  <= '0;
      wcnt_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hunt_q  <= hunt_d;
      pack_q  <= pack_d;
      byte_q  <= byte_d;
      idle_q  <= idle_d;
      wcnt_q  <= wcnt_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign fifo_wr_data = wdata_q;
  assign fifo_wr_en   = wen_q;
  assign frame_active = (state_q == ST_RECV);
  assign frame_done   = done_q;
  assign err_timeout  = tmo_q;
  assign word_cnt     = wcnt_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Randomized bench for uart_frame_packer against an event-level
// model built from the byte stream and its timing.
module tb_uart_frame_packer;

  localparam int          FW   = 4;
  localparam int          TO   = 100;
  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_TMO  = 3;
  localparam int K_RISE = 4;
  localparam int K_FALL = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] fifo_wr_data;
  logic        fifo_wr_en;
  logic        frame_active;
  logic        frame_done;
  logic        err_timeout;
  logic [19:0] word_cnt;

  uart_frame_packer #(
    .FIFO_WR_WIDTH(32),
    .FIFO_WR_BYTE (4),
    .FRAME_WORDS  (FW),
    .SYNC_WORD    (SYNC),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en  (fifo_wr_en),
    .frame_active(frame_active),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .word_cnt    (word_cnt)
  );

  always #5 clk = ~clk;

  int stamp = 0;
  always @(posedge clk) stamp <= stamp + 1;

  typedef struct {
    int          kind;
    int          at;
    logic [31:0] data;
    int          cnt;
  } ev_t;

  ev_t        act[$];
  ev_t        exp_q[$];
  logic [7:0] bq[$];
  int         sq[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic       prev_act = 1'b0;

  function automatic ev_t ev(input int k, input int a,
                             input logic [31:0] d,
                             input int n);
    ev_t e;
    e.kind = k;
    e.at   = a;
    e.data = d;
    e.cnt  = n;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_act <= 1'b0;
    end else begin
      if (fifo_wr_en)
        act.push_back(ev(K_WR, stamp, fifo_wr_data,
                         int'(word_cnt)));
      if (frame_done)
        act.push_back(ev(K_DONE, stamp, 0, int'(word_cnt)));
      if (err_timeout)
        act.push_back(ev(K_TMO, stamp, 0, int'(word_cnt)));
      if (frame_active && !prev_act)
        act.push_back(ev(K_RISE, stamp, 0, int'(word_cnt)));
      if (!frame_active && prev_act)
        act.push_back(ev(K_FALL, stamp, 0, int'(word_cnt)));
      prev_act <= frame_active;
    end
  end

  task automatic put(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    bq.push_back(b);
    sq.push_back(stamp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic put_sync(input int gap);
    put(8'hA5, gap);
    put(8'hA5, 0);
    put(8'h5A, 0);
    put(8'h5A, 0);
  endtask

  task automatic add(input ev_t e);
    int i;
    i = 0;
    while (i < exp_q.size() &&
           exp_q[i].at * 8 + exp_q[i].kind <= e.at * 8 + e.kind)
      i++;
    exp_q.insert(i, e);
  endtask

  // Stream-level rules: sync = last four bytes seen while hunting,
  // four payload bytes make a word one cycle later, a gap of TO
  // idle cycles aborts, the byte right after the last word is lost.
  task automatic model(input bit flush);
    bit          recv;
    logic [7:0]  win[$];
    logic [31:0] cur;
    int          nb, wc, last, ign, c;
    logic [7:0]  b;
    recv = 0; cur = 0; nb = 0; wc = 0; last = 0; ign = -1;
    exp_q.delete();
    for (int i = 0; i < bq.size(); i++) begin
      b = bq[i];
      c = sq[i];
      if (recv && c - last - 1 >= TO) begin
        add(ev(K_TMO, last + TO + 1, 0, wc));
        add(ev(K_FALL, last + TO + 1, 0, wc));
        recv = 0;
        win.delete();
      end
      if (!recv) begin
        if (c != ign) begin
          win.push_back(b);
          if (win.size() > 4) void'(win.pop_front());
          if (win.size() == 4 &&
              {win[0], win[1], win[2], win[3]} == SYNC) begin
            recv = 1; win.delete();
            nb = 0; cur = 0; wc = 0; last = c;
            add(ev(K_RISE, c + 1, 0, 0));
          end
        end
      end else begin
        cur = cur * 256 + 32'(b);
        nb++;
        last = c;
        if (nb == 4) begin
          wc++;
          add(ev(K_WR, c + 1, cur, wc));
          nb = 0; cur = 0;
          if (wc == FW) begin
            add(ev(K_FALL, c + 1, 0, wc));
            add(ev(K_DONE, c + 2, 0, wc));
            recv = 0;
            ign = c + 1;
          end
        end
      end
    end
    if (flush && recv) begin
      add(ev(K_TMO, last + TO + 1, 0, wc));
      add(ev(K_FALL, last + TO + 1, 0, wc));
    end
  endtask

  task automatic compare(input string run, input bit flush);
    int n;
    model(flush);
    chk({run, "_nev"}, act.size(), exp_q.size());
    n = (act.size() < exp_q.size()) ? act.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_e%0d_kind", run, i),
          act[i].kind, exp_q[i].kind);
      chk($sformatf("%s_e%0d_at", run, i),
          act[i].at, exp_q[i].at);
      chk($sformatf("%s_e%0d_data", run, i),
          act[i].data, exp_q[i].data);
      chk($sformatf("%s_e%0d_cnt", run, i),
          act[i].cnt, exp_q[i].cnt);
    end
    act.delete();
    bq.delete();
    sq.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, fifo_wr_data, 0);
    chk({tag, "_en"}, fifo_wr_en, 0);
    chk({tag, "_act"}, frame_active, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_tmo"}, err_timeout, 0);
    chk({tag, "_wcnt"}, word_cnt, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    put_sync(2);
    put(8'h11, 1); put(8'h22, 1);
    put(8'h33, 1); put(8'h00, 1);
    idle(TO + 10);

    put(8'h00, 1); put(8'hA5, 1); put(8'hA5, 1);
    put(8'h5A, 1); put(8'h5A, 1); put(8'h5A, 1);
    put(8'hC1, 1); put(8'hC2, 1); put(8'hC3, 1);
    put(8'hC4, 1);
    idle(TO + 10);

    put_sync(1);
    for (int i = 0; i < 4 * FW; i++)
      put(8'(8'h40 + i), 1);
    put(8'hEE, 0);
    idle(TO + 10);

    put_sync(1);
    put(8'h01, 1); put(8'h02, 1);
    idle(TO + 10);
    put_sync(1);
    put(8'hD0, 1); put(8'hD1, 1);
    put(8'hD2, 1); put(8'hD3, 1);
    idle(TO + 10);

    put_sync(1);
    put(8'h71, 1); put(8'h72, 1); put(8'h73, 1);
    put(8'h74, TO - 1);
    put(8'h81, 1); put(8'h82, 1); put(8'h83, 1);
    put(8'h84, TO);
    idle(TO + 10);

    for (int s = 0; s < 25; s++) begin
      int nj, np, g, r;
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++)
        put(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      put_sync($urandom_range(0, 2));
      np = $urandom_range(0, 14);
      for (int j = 0; j < np; j++) begin
        r = $urandom_range(0, 19);
        if (r == 0) g = TO - 1;
        else if (r == 1) g = TO;
        else if (r == 2) g = TO + 1;
        else g = $urandom_range(0, 3);
        if (r == 3) put_sync(g);
        else put(8'($urandom_range(0, 255)), g);
      end
      if ($urandom_range(0, 3) == 0) idle(TO + 5);
    end
    idle(TO + 10);
    compare("runA", 1'b1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    put_sync(1);
    for (int i = 0; i < 8; i++)
      put(8'(8'h90 + i), 1);
    idle(3);
    compare("runB", 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    put(8'h12, 1); put(8'h34, 1); put(8'h56, 1); put(8'h78, 1);
    put_sync(1);
    put(8'hAB, 1); put(8'hCD, 1); put(8'hEF, 1); put(8'h01, 1);
    idle(TO + 10);
    compare("runC", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
